as_alu: RTL and testbench

- Integer ALU for the rv64i core execute stage.
- Combinational operation decode and compute, followed by one output register stage.
- Produces a REG_WIDTH result plus zero and negative flags, consumed by writeback and branch compare logic.
- Opcode is the 4-bit ALU select from the main decoder (package constant alusel_width).

---
 rtl/as_alu.sv | 114 +++++++++++
 tb/tb_as_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/as_alu.sv
// as_alu: rv64i integer ALU -- combinational decode/compute followed by one output register stage.
// Define AS_ALU_WORD_OPS_EN to enable the 32-bit W ops (codes 1010-1110); legal only with REG_WIDTH=64.
module as_alu #(
  parameter int REG_WIDTH    = 64,
  parameter int ALUSEL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_WIDTH-1:0]    data01,
  input  logic [REG_WIDTH-1:0]    data02,
  input  logic [ALUSEL_WIDTH-1:0] aluSel,
  input  logic                    aluValid,
  output logic                    aluZero,
  output logic                    aluNega,
  output logic [REG_WIDTH-1:0]    aluResult,
  output logic                    aluValidOut
);

  localparam int SHAMT_W = (REG_WIDTH == 64) ? 6 : 5;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100, OP_SRL  = 4'b0101, OP_SUB  = 4'b0110, OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_ADDW = 4'b1010, OP_SUBW = 4'b1011,
    OP_SLLW = 4'b1100, OP_SRLW = 4'b1101, OP_SRAW = 4'b1110, OP_RSVD = 4'b1111
  } alu_op_e;

  alu_op_e              op;
  logic [SHAMT_W-1:0]   shamt;
  logic [REG_WIDTH-1:0] alu_out;

  logic [REG_WIDTH-1:0] result_d, result_q;
  logic                 zero_d,   zero_q;
  logic                 nega_d,   nega_q;
  logic                 valid_d,  valid_q;

  assign op    = alu_op_e'(aluSel);
  assign shamt = data02[SHAMT_W-1:0];

`ifdef AS_ALU_WORD_OPS_EN
  logic [31:0] w_res;
  logic [4:0]  w_shamt;

  assign w_shamt = data02[4:0];

  always_comb begin
    w_res = '0;
    unique case (op)
      OP_ADDW: w_res = data01[31:0] + data02[31:0];
      OP_SUBW: w_res = data01[31:0] - data02[31:0];
      OP_SLLW: w_res = data01[31:0] << w_shamt;
      OP_SRLW: w_res = data01[31:0] >> w_shamt;
      OP_SRAW: w_res = $signed(data01[31:0]) >>> w_shamt;
      default: w_res = '0;
    endcase
  end
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_out = '0;
    case (op)
      OP_AND:  alu_out = data01 & data02;
      OP_OR:   alu_out = data01 | data02;
      OP_ADD:  alu_out = data01 + data02;
      OP_XOR:  alu_out = data01 ^ data02;
      OP_SLL:  alu_out = data01 << shamt;
      OP_SRL:  alu_out = data01 >> shamt;
      OP_SUB:  alu_out = data01 - data02;
      OP_SRA:  alu_out = $signed(data01) >>> shamt;
      OP_SLT:  alu_out = {{(REG_WIDTH-1){1'b0}}, ($signed(data01) < $signed(data02))};
      OP_SLTU: alu_out = {{(REG_WIDTH-1){1'b0}}, (data01 < data02)};
`ifdef AS_ALU_WORD_OPS_EN
      OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW:
               alu_out = {{(REG_WIDTH-32){w_res[31]}}, w_res};
`endif
      default: alu_out = '0;
    endcase
  end

  // Flags derive from the same value that is registered, so they can never disagree with aluResult.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    nega_d   = nega_q;
    valid_d  = aluValid;
    if (aluValid) begin
      result_d = alu_out;
      zero_d   = (alu_out == '0);
      nega_d   = alu_out[REG_WIDTH-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      nega_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      nega_q   <= nega_d;
      valid_q  <= valid_d;
    end
  end

  assign aluResult   = result_q;
  assign aluZero     = zero_q;
  assign aluNega     = nega_q;
  assign aluValidOut = valid_q;

endmodule

// File: tb/tb_as_alu.sv
// tb_as_alu: self-checking bench for as_alu (REG_WIDTH=64) with directed vectors and a randomized reference model.
module tb_as_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data01, data02;
  logic [3:0]  aluSel;
  logic        aluValid;
  logic        aluZero, aluNega, aluValidOut;
  logic [63:0] aluResult;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs should show after the last edge.
  logic [63:0] m_res = '0;
  logic        m_vld = 1'b0;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  sel;
    logic [63:0] exp;
  } vec_t;

  as_alu #(.REG_WIDTH(64), .ALUSEL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .data01(data01), .data02(data02), .aluSel(aluSel),
    .aluValid(aluValid), .aluZero(aluZero), .aluNega(aluNega),
    .aluResult(aluResult), .aluValidOut(aluValidOut)
  );

  always #5 clk = ~clk;

  // Arithmetic reference written from the operation definitions, not from the RTL structure.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel);
    logic [63:0] msb = 64'h8000_0000_0000_0000;
    int unsigned s   = b[5:0];
    int unsigned s5  = b[4:0];
    logic [31:0] lo;
    logic [63:0] r   = '0;
    lo = '0;
    case (sel)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a << s;
      4'd5:  r = a >> s;
      4'd6:  r = a + ~b + 64'd1;
      4'd7:  r = (a >> s) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> s) : 64'd0);
      4'd8:  r = ((a ^ msb) < (b ^ msb)) ? 64'd1 : 64'd0;
      4'd9:  r = (a < b) ? 64'd1 : 64'd0;
`ifdef AS_ALU_WORD_OPS_EN
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14: begin
        case (sel)
          4'd10:   lo = a[31:0] + b[31:0];
          4'd11:   lo = a[31:0] + ~b[31:0] + 32'd1;
          4'd12:   lo = a[31:0] << s5;
          4'd13:   lo = a[31:0] >> s5;
          default: lo = (a[31:0] >> s5) | (a[31] ? ~(32'hFFFF_FFFF >> s5) : 32'd0);
        endcase
        r = {{32{lo[31]}}, lo};
      end
`endif
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Drives one cycle of stimulus, waits past the edge, and advances the model.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel, input logic v);
    data01   = a;
    data02   = b;
    aluSel   = sel;
    aluValid = v;
    @(posedge clk);
    #1;
    if (rst) begin
      m_res = '0;
      m_vld = 1'b0;
    end else begin
      if (v) m_res = model(a, b, sel);
      m_vld = v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'(i + 2), 1'b1);
      n_checks++;
      if ({aluValidOut, aluNega, aluZero, aluResult} !== {1'b0, 1'b0, 1'b1, 64'd0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got vo=%b n=%b z=%b r=%h, exp vo=0 n=0 z=1 r=0",
                 i, aluValidOut, aluNega, aluZero, aluResult);
      end
    end
    // An operation in flight when reset is asserted must be discarded.
    rst = 1'b0;
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 4'd1, 1'b1);
    rst = 1'b1;
    drive(64'h8000_0000_0000_0000, 64'd1, 4'd2, 1'b1);
    n_checks++;
    if ({aluValidOut, aluNega, aluZero, aluResult} !== {1'b0, 1'b0, 1'b1, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_in_flight: got vo=%b n=%b z=%b r=%h, exp vo=0 n=0 z=1 r=0",
               aluValidOut, aluNega, aluZero, aluResult);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [63:0] w_exp;
`ifdef AS_ALU_WORD_OPS_EN
    w_exp = 64'hFFFF_FFFF_8000_0000;
`else
    w_exp = 64'd0;
`endif
    v.push_back('{"and_zero",  64'd0,  64'd0,  4'b0000, 64'd0});
    v.push_back('{"or_zero",   64'd0,  64'd0,  4'b0001, 64'd0});
    v.push_back('{"and",       64'hF,  64'hA,  4'b0000, 64'hA});
    v.push_back('{"or",        64'hF,  64'hA,  4'b0001, 64'hF});
    v.push_back('{"add_zero",  64'd0,  64'd0,  4'b0010, 64'd0});
    v.push_back('{"add",       64'hF,  64'hA,  4'b0010, 64'h19});
    v.push_back('{"sub_neg",   64'hA,  64'hF,  4'b0110, 64'hFFFF_FFFF_FFFF_FFFB});
    v.push_back('{"add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0});
    v.push_back('{"sra",       64'h8000_0000_0000_0000, 64'h41, 4'b0111, 64'hC000_0000_0000_0000});
    v.push_back('{"srl",       64'h8000_0000_0000_0000, 64'h41, 4'b0101, 64'h4000_0000_0000_0000});
    v.push_back('{"slt",       64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 64'd1});
    v.push_back('{"sltu",      64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 64'd0});
    v.push_back('{"sra_63",    64'h8000_0000_0000_0001, 64'h3F, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{"sll_hi_ig", 64'h1234, 64'hFFC0, 4'b0100, 64'h1234});
    v.push_back('{"sll_63",    64'd1,  64'd63, 4'b0100, 64'h8000_0000_0000_0000});
    v.push_back('{"slt_minmax",64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1000, 64'd1});
    v.push_back('{"xor_self",  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 4'b0011, 64'd0});
    v.push_back('{"reserved",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 64'd0});
    v.push_back('{"addw",      64'h7FFF_FFFF, 64'd1, 4'b1010, w_exp});
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].sel, 1'b1);
      n_checks++;
      if ({aluValidOut, aluNega, aluZero, aluResult} !== {1'b1, v[i].exp[63], v[i].exp == 64'd0, v[i].exp}) begin
        n_fail++;
        $display("FAIL %s: got vo=%b n=%b z=%b r=%h, exp vo=1 n=%b z=%b r=%h", v[i].name,
                 aluValidOut, aluNega, aluZero, aluResult, v[i].exp[63], v[i].exp == 64'd0, v[i].exp);
      end
    end
  endtask

  task automatic test_hold();
    drive(64'hF, 64'hA, 4'b0010, 1'b1);
    drive(64'h1111, 64'h2222, 4'b0110, 1'b0);
    n_checks++;
    if ({aluValidOut, aluNega, aluZero, aluResult} !== {1'b0, 1'b0, 1'b0, 64'h19}) begin
      n_fail++;
      $display("FAIL hold: got vo=%b n=%b z=%b r=%h, exp vo=0 n=0 z=0 r=19",
               aluValidOut, aluNega, aluZero, aluResult);
    end
    drive(64'h0, 64'h0, 4'b0001, 1'b0);
    n_checks++;
    if ({aluValidOut, aluResult} !== {1'b0, 64'h19}) begin
      n_fail++;
      $display("FAIL hold2: got vo=%b r=%h, exp vo=0 r=19", aluValidOut, aluResult);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 64'h8000_0000_0000_0000 >> $urandom_range(0, 40);
        1: b = 64'($urandom_range(0, 255));
        2: b = a;
        3: a = {32'd0, $urandom};
        default: ;
      endcase
      drive(a, b, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      n_checks++;
      if ({aluValidOut, aluNega, aluZero, aluResult} !== {m_vld, m_res[63], m_res == 64'd0, m_res}) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h sel=%h v=%b: got vo=%b n=%b z=%b r=%h, exp vo=%b n=%b z=%b r=%h",
                 i, a, b, aluSel, aluValid, aluValidOut, aluNega, aluZero, aluResult,
                 m_vld, m_res[63], m_res == 64'd0, m_res);
      end
    end
  endtask

  initial begin
    rst = 1'b1; data01 = '0; data02 = '0; aluSel = '0; aluValid = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
